accum_alu: RTL and testbench
============================

ACCUM_ALU -- requirements
Module: accum_alu

Interface
REQ-001 The block SHALL have parameter WIDTH, default 8, giving the operand, accumulator and result width in bits (legal range 4..32).
REQ-002 The block SHALL have port clk, input, 1 bit: the single clock; all state changes occur on its rising edge.
REQ-003 The block SHALL have port rst, input, 1 bit: reset, asynchronous and active-low.
REQ-004 The block SHALL have port on, input, 1 bit: power enable; 0 forces the block off.
REQ-005 The block SHALL have port start, input, 1 bit: operation request, sampled only in READY.
REQ-006 The block SHALL have port op, input, 3 bits: operation select (000 AND, 001 OR, 010 XOR, 011 NOT A, 100 ADD, 101 SUB, 110 MUL, 111 PASS A).
REQ-007 The block SHALL have port acc_sel, input, 1 bit: operand A source (1 = accumulator, 0 = a_in).
REQ-008 The block SHALL have port clear, input, 1 bit: synchronous clear of the accumulator and the error flag.
REQ-009 The block SHALL have ports a_in and b_in, input, WIDTH bits each: the operands.
REQ-010 The block SHALL have port result, output, WIDTH bits: the accumulator value.
REQ-011 The block SHALL have outputs busy (1 bit), done (1 bit), ovf (1 bit), err (1 bit) and state (2 bits).

Function
REQ-012 The FSM SHALL use the encodings OFF=00, READY=01, RUN=10 and ERROR=11, and state SHALL show the current state.
REQ-013 OFF SHALL go to READY when on=1; with on=0 in any state, the next state SHALL be OFF, any operation SHALL be aborted with no done, and the accumulator SHALL be kept.
REQ-014 In READY, start=1 SHALL latch A (accumulator or a_in, per acc_sel), b_in and op, enter RUN and set busy=1 from the next cycle.
REQ-015 In states other than READY, start SHALL be ignored, and input changes during RUN SHALL not affect the operation in flight.
REQ-016 All ops except MUL SHALL complete in the first RUN cycle, so done and the updated result appear 2 cycles after the start edge.
REQ-017 MUL SHALL be a sequential shift-add over WIDTH RUN cycles forming a 2*WIDTH product; result SHALL be the low WIDTH bits, and done SHALL appear WIDTH+1 cycles after the start edge.
REQ-018 On completion the result SHALL be written to the accumulator, done SHALL pulse for exactly 1 cycle, and busy SHALL return to 0 in the same cycle.
REQ-019 Overflow SHALL be detected as follows: ADD on unsigned carry out; SUB on borrow (A<B), with the wrapped difference stored; MUL when the high product half is nonzero; all other ops never overflow.
REQ-020 The ovf output SHALL be valid with done, holding the overflow of the last completed op.
REQ-021 On a completion with overflow, the FSM SHALL go to ERROR, otherwise to READY, and ERROR SHALL last exactly 1 cycle and then go to READY.
REQ-022 err SHALL be set on entry to ERROR and SHALL stay 1 (sticky) until clear=1 or reset.
REQ-023 clear=1 in READY or ERROR SHALL zero the accumulator and err in the next cycle.
REQ-024 clear=1 in RUN SHALL abort the operation, zero the accumulator and err, return to READY, and produce no done.
REQ-025 When clear=1 and start=1 occur in the same READY cycle, clear SHALL win and start SHALL be dropped.
REQ-026 All arithmetic SHALL be unsigned modulo 2^WIDTH, and NOT SHALL act on A only.

Reset
REQ-027 While rst=0, state SHALL be OFF, result SHALL be 0, and busy, done, ovf and err SHALL be 0.
REQ-028 Reset SHALL act immediately, independent of clk.
REQ-029 Assertion of rst mid-RUN SHALL discard the operation with no done.
REQ-030 After release of rst, the block SHALL stay in OFF until on=1 is sampled.

Verification
REQ-031 The bench SHALL check, for WIDTH=8: on=1, ADD a_in=0x0F b_in=0x01 acc_sel=0 -> done 2 cycles after start, result=0x10, ovf=0, state back to READY.
REQ-032 The bench SHALL check, for WIDTH=8: ADD 0xF0+0x20 -> result=0x10, ovf=1, state RUN->ERROR->READY, with err=1 held until clear pulse, then err=0 and result=0x00.
REQ-033 The bench SHALL check, for WIDTH=8: MUL 0x0C*0x0A -> done at cycle 9 after start, result=0x78, ovf=0; MUL 0x20*0x10 -> result=0x00, ovf=1.
REQ-034 The bench SHALL check accumulator chaining: acc=0x05, SUB acc_sel=1 b_in=0x07 -> result=0xFE, ovf=1; then PASS A acc_sel=1 -> result=0xFE.
REQ-035 The bench SHALL check aborts: clear at RUN cycle 3 of MUL -> no done, result=0, READY next cycle; on=0 mid-MUL -> OFF, no done, accumulator unchanged.
REQ-036 The bench SHALL check asynchronous reset: rst=0 between clock edges mid-RUN -> outputs zero immediately, state=OFF; start with on=0 -> ignored.

Source files
------------

// File: rtl/accum_alu.sv
// Accumulator ALU: single-issue logic/arithmetic unit with an internal accumulator,
// a sequential shift-add multiplier, sticky error flag and a power/abort FSM.
module accum_alu #(
    parameter int unsigned WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             on,
    input  logic             start,
    input  logic [2:0]       op,
    input  logic             acc_sel,
    input  logic             clear,
    input  logic [WIDTH-1:0] a_in,
    input  logic [WIDTH-1:0] b_in,
    output logic [WIDTH-1:0] result,
    output logic             busy,
    output logic             done,
    output logic             ovf,
    output logic             err,
    output logic [1:0]       state
);

    localparam int unsigned CW = $clog2(WIDTH + 1);

    localparam logic [1:0] ST_OFF   = 2'b00;
    localparam logic [1:0] ST_READY = 2'b01;
    localparam logic [1:0] ST_RUN   = 2'b10;
    localparam logic [1:0] ST_ERROR = 2'b11;

    localparam logic [2:0] OP_AND  = 3'b000;
    localparam logic [2:0] OP_OR   = 3'b001;
    localparam logic [2:0] OP_XOR  = 3'b010;
    localparam logic [2:0] OP_NOT  = 3'b011;
    localparam logic [2:0] OP_ADD  = 3'b100;
    localparam logic [2:0] OP_SUB  = 3'b101;
    localparam logic [2:0] OP_MUL  = 3'b110;
    localparam logic [2:0] OP_PASS = 3'b111;

    logic [1:0]         state_q, state_d;
    logic [CW-1:0]      cnt_q, cnt_d;
    logic [WIDTH-1:0]   a_q, a_d;
    logic [WIDTH-1:0]   b_q, b_d;
    logic [2:0]         op_q, op_d;
    logic [2*WIDTH-1:0] prod_q, prod_d;
    logic [WIDTH-1:0]   acc_q, acc_d;
    logic               busy_q, busy_d;
    logic               done_q, done_d;
    logic               ovf_q, ovf_d;
    logic               err_q, err_d;

    logic [WIDTH:0]     add_c;
    logic [WIDTH:0]     sub_c;
    logic [WIDTH:0]     mul_sum_c;
    logic [WIDTH-1:0]   res_c;
    logic               res_ovf_c;
    logic [CW-1:0]      last_c;

    // Datapath: operation result and overflow from the latched operands
    always_comb begin
        add_c     = {1'b0, a_q} + {1'b0, b_q};
        sub_c     = {1'b0, a_q} - {1'b0, b_q};
        mul_sum_c = {1'b0, prod_q[2*WIDTH-1:WIDTH]} + {1'b0, (prod_q[0] ? a_q : '0)};
        res_c     = '0;
        res_ovf_c = 1'b0;
        case (op_q)
            OP_AND:  res_c = a_q & b_q;
            OP_OR:   res_c = a_q | b_q;
            OP_XOR:  res_c = a_q ^ b_q;
            OP_NOT:  res_c = ~a_q;
            OP_ADD:  begin res_c = add_c[WIDTH-1:0]; res_ovf_c = add_c[WIDTH]; end
            OP_SUB:  begin res_c = sub_c[WIDTH-1:0]; res_ovf_c = sub_c[WIDTH]; end
            OP_MUL:  begin res_c = prod_q[WIDTH-1:0]; res_ovf_c = |prod_q[2*WIDTH-1:WIDTH]; end
            default: res_c = a_q;
        endcase
        // Multiply needs WIDTH shift-add steps before the final write-back cycle
        last_c = (op_q == OP_MUL) ? CW'(WIDTH) : CW'(1);
    end

    // Next-state and output logic
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        a_d     = a_q;
        b_d     = b_q;
        op_d    = op_q;
        prod_d  = prod_q;
        acc_d   = acc_q;
        ovf_d   = ovf_q;
        err_d   = err_q;
        done_d  = 1'b0;

        if (!on) begin
            state_d = ST_OFF;
        end else begin
            case (state_q)
                ST_OFF: state_d = ST_READY;
                ST_READY: begin
                    if (clear) begin
                        acc_d = '0;
                        err_d = 1'b0;
                    end else if (start) begin
                        a_d     = acc_sel ? acc_q : a_in;
                        b_d     = b_in;
                        op_d    = op;
                        prod_d  = {{WIDTH{1'b0}}, b_in};
                        cnt_d   = '0;
                        state_d = ST_RUN;
                    end
                end
                ST_RUN: begin
                    if (clear) begin
                        acc_d   = '0;
                        err_d   = 1'b0;
                        state_d = ST_READY;
                    end else if (cnt_q == last_c) begin
                        acc_d   = res_c;
                        ovf_d   = res_ovf_c;
                        done_d  = 1'b1;
                        state_d = res_ovf_c ? ST_ERROR : ST_READY;
                        if (res_ovf_c) begin
                            err_d = 1'b1;
                        end
                    end else begin
                        cnt_d = cnt_q + CW'(1);
                        if (op_q == OP_MUL) begin
                            prod_d = {mul_sum_c, prod_q[WIDTH-1:1]};
                        end
                    end
                end
                default: begin
                    state_d = ST_READY;
                    if (clear) begin
                        acc_d = '0;
                        err_d = 1'b0;
                    end
                end
            endcase
        end

        busy_d = (state_d == ST_RUN);
    end

    // State and output registers
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= ST_OFF;
            cnt_q   <= '0;
            a_q     <= '0;
            b_q     <= '0;
            op_q    <= '0;
            prod_q  <= '0;
            acc_q   <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            ovf_q   <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            a_q     <= a_d;
            b_q     <= b_d;
            op_q    <= op_d;
            prod_q  <= prod_d;
            acc_q   <= acc_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            ovf_q   <= ovf_d;
            err_q   <= err_d;
        end
    end

    assign result = acc_q;
    assign busy   = busy_q;
    assign done   = done_q;
    assign ovf    = ovf_q;
    assign err    = err_q;
    assign state  = state_q;

endmodule

// File: tb/tb_accum_alu.sv
// Self-checking bench for accum_alu (WIDTH=8): directed scenarios plus random ops
// compared against an arithmetic reference model of the accumulator.
module tb_accum_alu;

    localparam int unsigned W = 8;

    logic         clk;
    logic         rst;
    logic         on;
    logic         start;
    logic [2:0]   op;
    logic         acc_sel;
    logic         clear;
    logic [W-1:0] a_in;
    logic [W-1:0] b_in;
    logic [W-1:0] result;
    logic         busy;
    logic         done;
    logic         ovf;
    logic         err;
    logic [1:0]   state;

    int checks = 0;
    int errors = 0;

    int unsigned m_acc = 0;
    bit          m_err = 1'b0;

    accum_alu #(.WIDTH(W)) dut (
        .clk(clk), .rst(rst), .on(on), .start(start), .op(op),
        .acc_sel(acc_sel), .clear(clear), .a_in(a_in), .b_in(b_in),
        .result(result), .busy(busy), .done(done), .ovf(ovf), .err(err),
        .state(state)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Reference: {ovf, result} from plain unsigned arithmetic
    function automatic logic [8:0] model(input logic [2:0] o, input int unsigned a, input int unsigned b);
        int unsigned r;
        bit v;
        v = 1'b0;
        case (o)
            3'd0: r = a & b;
            3'd1: r = a | b;
            3'd2: r = a ^ b;
            3'd3: r = (~a) & 32'hFF;
            3'd4: begin r = a + b; v = (r > 255); end
            3'd5: begin v = (a < b); r = (a + 256 - b) % 256; end
            3'd6: begin r = a * b; v = (r > 255); end
            default: r = a;
        endcase
        return {v, 8'(r % 256)};
    endfunction

    task automatic do_op(input string tag, input logic [2:0] o, input int unsigned a,
                         input int unsigned b, input bit sel);
        logic [8:0] exp;
        int unsigned lat;
        bit early;
        exp   = model(o, sel ? m_acc : a, b);
        lat   = (o == 3'd6) ? W + 1 : 2;
        op    = o;
        a_in  = W'(a);
        b_in  = W'(b);
        acc_sel = sel;
        start = 1'b1;
        tick();
        start   = 1'b0;
        op      = 3'($urandom_range(0, 7));
        a_in    = W'($urandom);
        b_in    = W'($urandom);
        acc_sel = 1'($urandom);
        check({tag, " busy"}, 32'(busy), 32'd1);
        check({tag, " run"}, 32'(state), 32'd2);
        early = 1'b0;
        for (int k = 1; k < int'(lat); k++) begin
            tick();
            if (done) early = 1'b1;
        end
        tick();
        check({tag, " early_done"}, 32'(early), 32'd0);
        check({tag, " done"}, 32'(done), 32'd1);
        check({tag, " result"}, 32'(result), 32'(exp[7:0]));
        check({tag, " ovf"}, 32'(ovf), 32'(exp[8]));
        check({tag, " busy_off"}, 32'(busy), 32'd0);
        check({tag, " end_state"}, 32'(state), exp[8] ? 32'd3 : 32'd1);
        m_acc = 32'(exp[7:0]);
        if (exp[8]) m_err = 1'b1;
        check({tag, " err"}, 32'(err), 32'(m_err));
        tick();
        check({tag, " done_pulse"}, 32'(done), 32'd0);
        check({tag, " ready"}, 32'(state), 32'd1);
    endtask

    task automatic pulse_clear(input string tag);
        clear = 1'b1;
        tick();
        clear = 1'b0;
        m_acc = 0;
        m_err = 1'b0;
        check({tag, " clr_result"}, 32'(result), 32'd0);
        check({tag, " clr_err"}, 32'(err), 32'd0);
    endtask

    initial begin
        bit seen;
        rst = 1'b0; on = 1'b0; start = 1'b0; op = '0; acc_sel = 1'b0;
        clear = 1'b0; a_in = '0; b_in = '0;
        tick();
        tick();
        check("rst state", 32'(state), 32'd0);
        check("rst outs", {busy, done, ovf, err, 24'(result)}, 32'd0);
        rst = 1'b1;
        start = 1'b1;
        tick();
        tick();
        check("off_hold", 32'(state), 32'd0);
        start = 1'b0;
        on = 1'b1;
        tick();
        check("power_on", 32'(state), 32'd1);

        do_op("add_basic", 3'd4, 32'h0F, 32'h01, 1'b0);
        check("add_basic lit", 32'(result), 32'h10);

        do_op("add_ovf", 3'd4, 32'hF0, 32'h20, 1'b0);
        check("add_ovf lit", 32'(result), 32'h10);
        tick(); tick();
        check("err_sticky", 32'(err), 32'd1);
        pulse_clear("add_ovf");

        do_op("mul_small", 3'd6, 32'h0C, 32'h0A, 1'b0);
        check("mul_small lit", 32'(result), 32'h78);
        do_op("mul_ovf", 3'd6, 32'h20, 32'h10, 1'b0);
        pulse_clear("mul_ovf");

        do_op("load5", 3'd7, 32'h05, 32'h00, 1'b0);
        do_op("sub_chain", 3'd5, 32'h00, 32'h07, 1'b1);
        check("sub_chain lit", 32'(result), 32'hFE);
        do_op("pass_chain", 3'd7, 32'h00, 32'h00, 1'b1);
        check("pass_chain lit", 32'(result), 32'hFE);
        pulse_clear("chain");

        for (int i = 0; i < 24; i++) begin
            do_op("rand", 3'($urandom_range(0, 7)), $urandom_range(0, 255),
                  $urandom_range(0, 255), 1'($urandom));
            if ($urandom_range(0, 5) == 0) pulse_clear("rand");
        end

        // Clear and start together: clear wins
        do_op("preload", 3'd7, 32'h5A, 32'h00, 1'b0);
        start = 1'b1; clear = 1'b1; op = 3'd7; a_in = 8'h33;
        tick();
        start = 1'b0; clear = 1'b0;
        m_acc = 0; m_err = 1'b0;
        check("clr_start state", 32'(state), 32'd1);
        check("clr_start result", 32'(result), 32'd0);

        // Clear during MUL RUN cycle 3
        do_op("preload2", 3'd7, 32'h44, 32'h00, 1'b0);
        op = 3'd6; a_in = 8'h0C; b_in = 8'h0A; acc_sel = 1'b0; start = 1'b1;
        tick();
        start = 1'b0;
        tick(); tick();
        clear = 1'b1;
        tick();
        clear = 1'b0;
        check("mul_clr state", 32'(state), 32'd1);
        check("mul_clr result", 32'(result), 32'd0);
        check("mul_clr busy", 32'(busy), 32'd0);
        seen = done;
        for (int k = 0; k < 10; k++) begin tick(); if (done) seen = 1'b1; end
        check("mul_clr no_done", 32'(seen), 32'd0);
        m_acc = 0; m_err = 1'b0;

        // Power off mid-MUL keeps the accumulator
        do_op("preload3", 3'd7, 32'h3C, 32'h00, 1'b0);
        op = 3'd6; a_in = 8'h03; b_in = 8'h05; start = 1'b1;
        tick();
        start = 1'b0;
        tick(); tick(); tick();
        on = 1'b0;
        tick();
        check("off_abort state", 32'(state), 32'd0);
        check("off_abort result", 32'(result), 32'h3C);
        seen = done;
        for (int k = 0; k < 10; k++) begin tick(); if (done) seen = 1'b1; end
        check("off_abort no_done", 32'(seen), 32'd0);
        on = 1'b1;
        tick();
        check("off_abort ready", 32'(state), 32'd1);
        check("off_abort keep", 32'(result), 32'h3C);

        // Asynchronous reset mid-RUN
        op = 3'd6; a_in = 8'h0F; b_in = 8'h0F; start = 1'b1;
        tick();
        start = 1'b0;
        tick(); tick();
        #2 rst = 1'b0;
        #1;
        check("async_rst state", 32'(state), 32'd0);
        check("async_rst outs", {busy, done, ovf, err, 24'(result)}, 32'd0);
        m_acc = 0; m_err = 1'b0;
        on = 1'b0;
        #3 rst = 1'b1;
        start = 1'b1;
        tick(); tick(); tick();
        check("start_off ignored", 32'(state), 32'd0);
        seen = done;
        for (int k = 0; k < 10; k++) begin tick(); if (done) seen = 1'b1; end
        check("rst no_done", 32'(seen), 32'd0);
        start = 1'b0;
        on = 1'b1;
        tick();
        check("rst_power_on", 32'(state), 32'd1);
        do_op("post_rst", 3'd4, 32'h21, 32'h12, 1'b1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
